// File: rtl/fp_issue_sched_if.sv
// Handshake bundle between FP decode, the issue scheduler and the FP writeback/forwarding logic.
// The master side is FP decode; the slave side is the scheduler.
interface fp_issue_sched_if;
  logic        id_valid;
  logic        id_fp_write;
  logic        id_is_div;
  logic [4:0]  id_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        flush;
  logic        issue;
  logic        stall;
  logic        div_start;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_sel;
  logic [31:0] pending;

  modport master (
    output id_valid, id_fp_write, id_is_div, id_rd, id_rs1, id_rs2,
           id_use_rs1, id_use_rs2, flush,
    input  issue, stall, div_start, wb_valid, wb_rd, wb_sel, pending
  );

  modport slave (
    input  id_valid, id_fp_write, id_is_div, id_rd, id_rs1, id_rs2,
           id_use_rs1, id_use_rs2, flush,
    output issue, stall, div_start, wb_valid, wb_rd, wb_sel, pending
  );
endinterface

// File: rtl/fp_issue_sched.sv
// FP issue scheduler: hazard checks for the ID instruction, in-flight destination scoreboard,
// writeback-slot reservation for the single FP writeback port, and FDIV busy tracking.
module fp_issue_sched #(
  parameter int PIPE_LAT = 4,
  parameter int DIV_LAT  = 12
) (
  input logic              clk,
  input logic              rst,
  fp_issue_sched_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       sel;
  } res_t;

  // res_q[k] describes the writeback happening k cycles from now; res_q[0] is this cycle's.
  res_t             res_q [DIV_LAT];
  res_t             res_d [DIV_LAT];
  logic [31:0]      pending_q, pending_d;
  logic [CNT_W-1:0] div_cnt_q;

  logic active, raw1, raw2, waw, div_busy, port_busy, hazard, issue_w;

  assign active = bus.id_valid & ~bus.flush & ~rst;

  // A source written back this very cycle is forwarded, so it is not a RAW hazard.
  assign raw1 = bus.id_use_rs1 & pending_q[bus.id_rs1]
              & ~(res_q[0].valid & (res_q[0].rd == bus.id_rs1));
  assign raw2 = bus.id_use_rs2 & pending_q[bus.id_rs2]
              & ~(res_q[0].valid & (res_q[0].rd == bus.id_rs2));
  assign waw       = bus.id_fp_write & pending_q[bus.id_rd];
  assign div_busy  = bus.id_is_div & (div_cnt_q > CNT_W'(1));
  // Nothing can already hold the slot DIV_LAT ahead, so only pipelined ops can collide.
  assign port_busy = bus.id_fp_write & ~bus.id_is_div & res_q[PIPE_LAT].valid;

  assign hazard  = raw1 | raw2 | waw | div_busy | port_busy;
  assign issue_w = active & ~hazard;

  assign bus.issue     = issue_w;
  assign bus.stall     = active & hazard;
  assign bus.div_start = issue_w & bus.id_is_div;
  assign bus.wb_valid  = res_q[0].valid;
  assign bus.wb_rd     = res_q[0].rd;
  assign bus.wb_sel    = res_q[0].sel;
  assign bus.pending   = pending_q;

  // NOTE: every variable driven here gets a default first so no latch can be inferred.
  always_comb begin
    for (int i = 0; i < DIV_LAT - 1; i++) res_d[i] = res_q[i + 1];
    res_d[DIV_LAT-1] = '0;
    pending_d = pending_q;
    if (res_q[0].valid) pending_d[res_q[0].rd] = 1'b0;
    if (issue_w && bus.id_fp_write) begin
      pending_d[bus.id_rd] = 1'b1;
      if (bus.id_is_div) res_d[DIV_LAT-1]  = '{valid: 1'b1, rd: bus.id_rd, sel: 1'b1};
      else               res_d[PIPE_LAT-1] = '{valid: 1'b1, rd: bus.id_rd, sel: 1'b0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the reservation store is reset because its valid bits drive wb_valid directly.
      for (int i = 0; i < DIV_LAT; i++) res_q[i] <= '0;
      pending_q <= '0;
      div_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DIV_LAT; i++) res_q[i] <= res_d[i];
      pending_q <= pending_d;
      if (bus.div_start)       div_cnt_q <= CNT_W'(DIV_LAT);
      else if (div_cnt_q != 0) div_cnt_q <= div_cnt_q - CNT_W'(1);
    end
  end

endmodule
